serial_adder_digit: RTL

Parametrised digit-serial adder/subtractor: consumes one DIGIT_W-bit digit pair per valid cycle, LSB digit first, and emits one sum digit per valid cycle. Carry is held across vld gaps rather than cleared, and the operation mode is latched per word. Per-word carry/borrow and signed-overflow flags are produced on the last digit, with a hard word-length limit. It sits between serial operand sources and downstream serial consumers in the sequential-arithmetic datapath.

---
 rtl/serial_arith_pkg.sv | 19 +
 rtl/digit_add.sv | 32 +++
 rtl/serial_adder_digit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared types and helpers for the digit-serial arithmetic blocks.
//   mode_t      : per-word operation (add / subtract)
//   cnt_width() : width of a digit counter that covers 0 .. max_digits-1
// -----------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_t;

  // Kept at a minimum of 1 so the counter never collapses to zero width.
  function automatic int cnt_width(input int max_digits);
    return (max_digits > 1) ? $clog2(max_digits) : 1;
  endfunction

endpackage : serial_arith_pkg

// File: rtl/digit_add.sv
// -----------------------------------------------------------------------------
// digit_add
// Combinational DIGIT_W-bit adder slice for digit-serial datapaths.
// Ports:
//   cin      in   carry into bit 0
//   a, b     in   operand digits
//   sum      out  result digit
//   cout     out  carry out of the digit MSB
//   c_msb_in out  carry into the digit MSB (for signed-overflow detection)
// -----------------------------------------------------------------------------
module digit_add #(
  parameter int DIGIT_W = 4
) (
  input  logic               cin,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout,
  output logic               c_msb_in
);

  logic [DIGIT_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
  assign sum  = full[DIGIT_W-1:0];
  assign cout = full[DIGIT_W];

  // A sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out of the
  // MSB bits alone; this also holds for DIGIT_W == 1, where it equals cin.
  assign c_msb_in = a[DIGIT_W-1] ^ b[DIGIT_W-1] ^ sum[DIGIT_W-1];

endmodule : digit_add

// File: rtl/serial_adder_digit.sv
// -----------------------------------------------------------------------------
// serial_adder_digit
// Digit-serial adder/subtractor, LSB digit first. Carry is held across vld
// gaps; the add/sub mode is latched on the first digit of each word. Carry,
// signed-overflow and length-error flags are reported with the last digit.
//
// Configuration macro: SERIAL_ADDER_OUT_REG_EN
//   defined   -> all outputs registered, latency 1
//   undefined -> outputs combinational from inputs and state, latency 0
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset, discards a partial word
//   vld        in   input digit valid
//   a, b       in   operand digits
//   sub        in   mode for the word, sampled on its first valid digit
//   last       in   final digit of word (only honoured with vld)
//   sum        out  result digit
//   sum_vld    out  result digit valid
//   sum_last   out  result digit is the final digit of the word
//   carry_out  out  carry from the final digit (sub: 1 = no borrow)
//   overflow   out  two's-complement overflow of the whole word
//   err        out  word forced to end at MAX_DIGITS without last
// -----------------------------------------------------------------------------
module serial_adder_digit
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  input  logic               last,
  output logic [DIGIT_W-1:0] sum,
  output logic               sum_vld,
  output logic               sum_last,
  output logic               carry_out,
  output logic               overflow,
  output logic               err
);

  localparam int CNT_W = cnt_width(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DIGITS - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_IN_WORD = 1'b1
  } state_t;

  // Output bundle, shared by the combinational and registered output paths.
  typedef struct packed {
    logic [DIGIT_W-1:0] sum;
    logic               vld;
    logic               last;
    logic               carry_out;
    logic               overflow;
    logic               err;
  } out_t;

  state_t           state_q, state_d;
  mode_t            mode_q,  mode_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic               first;
  mode_t              mode_eff;
  logic               cin;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W-1:0] dsum;
  logic               dcout;
  logic               dc_msb;
  logic               at_limit;
  logic               term;
  out_t               out_c;

  // First digit uses the live sub input; later digits use the latched mode.
  assign first    = vld && (state_q == ST_IDLE);
  assign mode_eff = first ? mode_t'(sub) : mode_q;
  assign cin      = first ? sub : carry_q;
  assign b_eff    = (mode_eff == MODE_SUB) ? ~b : b;
  assign at_limit = (cnt_q == CNT_LIMIT);
  assign term     = vld && (last || at_limit);

  digit_add #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_add (
    .cin      (cin),
    .a        (a),
    .b        (b_eff),
    .sum      (dsum),
    .cout     (dcout),
    .c_msb_in (dc_msb)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous, so it lives inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal gets its hold value first so no path through this
  // block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (vld) begin
      if (term) begin
        state_d = ST_IDLE;
        mode_d  = MODE_ADD;
        carry_d = 1'b0;
        cnt_d   = '0;
      end else begin
        state_d = ST_IN_WORD;
        mode_d  = mode_eff;
        carry_d = dcout;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // Flags are gated by term so they read 0 on every non-final digit.
  always_comb begin
    out_c           = '0;
    out_c.vld       = vld;
    out_c.sum       = vld ? dsum : '0;
    out_c.last      = term;
    out_c.carry_out = term & dcout;
    out_c.overflow  = term & (dc_msb ^ dcout);
    out_c.err       = term & ~last;
  end

`ifdef SERIAL_ADDER_OUT_REG_EN
  out_t out_q;

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_c;
  end

  assign sum       = out_q.sum;
  assign sum_vld   = out_q.vld;
  assign sum_last  = out_q.last;
  assign carry_out = out_q.carry_out;
  assign overflow  = out_q.overflow;
  assign err       = out_q.err;
`else
  out_t out_g;

  // Outputs are forced quiet while reset is held, even though the path is
  // combinational.
  assign out_g     = rst ? '0 : out_c;
  assign sum       = out_g.sum;
  assign sum_vld   = out_g.vld;
  assign sum_last  = out_g.last;
  assign carry_out = out_g.carry_out;
  assign overflow  = out_g.overflow;
  assign err       = out_g.err;
`endif

endmodule : serial_adder_digit
